// File: rtl/coin_changer.sv
// Beverage vending controller: collects coins, vends at PRICE and hands back change one coin at a time.
// Moore outputs (one cycle after inputs are sampled); in RETURN the dispenser stalls change via disp_ready.
module coin_changer #(
  parameter int PRICE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] x,
  input  logic       cancel,
  input  logic       disp_ready,
  output logic       y,
  output logic       coin_valid,
  output logic [1:0] coin_out,
  output logic [2:0] credit
);

  localparam logic [1:0] COLLECT = 2'd0;
  localparam logic [1:0] VEND    = 2'd1;
  localparam logic [1:0] RETURN  = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [2:0] credit_nxt;
  logic [1:0] add;
  logic [3:0] sum;
  logic [1:0] coin_val;

  always_comb begin
    add = 2'd0;
    case (x)
      2'b01:   add = 2'd1;
      2'b10:   add = 2'd2;
      default: add = 2'd0;
    endcase
  end

  // Four bits so credit+add can be compared against PRICE without wrapping.
  assign sum      = {1'b0, credit} + {2'b00, add};
  assign coin_val = (credit >= 3'd2) ? 2'd2 : 2'd1;

  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    case (state)
      COLLECT: begin
        if (cancel && (credit != 3'd0)) begin
          state_nxt = RETURN;
        end else if (sum >= 4'(PRICE)) begin
          // The difference always fits in three bits since credit < PRICE here.
          credit_nxt = sum[2:0] - 3'(PRICE);
          state_nxt  = VEND;
        end else begin
          credit_nxt = sum[2:0];
        end
      end
      VEND: begin
        state_nxt = (credit != 3'd0) ? RETURN : COLLECT;
      end
      RETURN: begin
        if (disp_ready) begin
          credit_nxt = credit - {1'b0, coin_val};
          if (credit_nxt == 3'd0) begin
            state_nxt = COLLECT;
          end
        end
      end
      default: begin
        state_nxt  = COLLECT;
        credit_nxt = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= COLLECT;
      credit <= 3'd0;
    end else begin
      state  <= state_nxt;
      credit <= credit_nxt;
    end
  end

  assign y          = (state == VEND);
  assign coin_valid = (state == RETURN);
  assign coin_out   = coin_valid ? coin_val : 2'b00;

endmodule

// File: tb/tb_coin_changer.sv
// Directed bench for coin_changer: a coin-queue model checked every cycle plus literal spot checks.
module tb_coin_changer;

  localparam int PRICE = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] x = 2'b00;
  logic       cancel = 1'b0;
  logic       disp_ready = 1'b0;
  logic       y;
  logic       coin_valid;
  logic [1:0] coin_out;
  logic [2:0] credit;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model: credit held while collecting, a vend flag, and the queue of change coins still owed.
  int m_credit = 0;
  bit m_vend = 1'b0;
  int q[$];

  coin_changer #(.PRICE(PRICE)) dut (
    .clk(clk), .rst(rst), .x(x), .cancel(cancel), .disp_ready(disp_ready),
    .y(y), .coin_valid(coin_valid), .coin_out(coin_out), .credit(credit)
  );

  always #5 clk = ~clk;

  function automatic void owe(input int c);
    int r;
    r = c;
    while (r >= 2) begin
      q.push_back(2);
      r -= 2;
    end
    if (r == 1) q.push_back(1);
  endfunction

  function automatic int owed();
    int s;
    s = 0;
    foreach (q[i]) s += q[i];
    return s;
  endfunction

  task automatic model_update();
    int add;
    int t;
    if (rst) begin
      m_credit = 0;
      m_vend   = 1'b0;
      q.delete();
    end else if (m_vend) begin
      m_vend = 1'b0;
    end else if (q.size() > 0) begin
      if (disp_ready) void'(q.pop_front());
    end else if (cancel && m_credit > 0) begin
      owe(m_credit);
      m_credit = 0;
    end else begin
      add = (x == 2'b01) ? 1 : (x == 2'b10) ? 2 : 0;
      t = m_credit + add;
      if (t >= PRICE) begin
        m_vend   = 1'b1;
        m_credit = 0;
        owe(t - PRICE);
      end else begin
        m_credit = t;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_y", int'(y), int'(m_vend));
      chk("model_coin_valid", int'(coin_valid), (!m_vend && q.size() > 0) ? 1 : 0);
      chk("model_coin_out", int'(coin_out), (!m_vend && q.size() > 0) ? q[0] : 0);
      chk("model_credit", int'(credit), m_credit + owed());
    end
  end

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step(input logic r, input logic [1:0] xi, input logic c, input logic d);
    rst = r;
    x = xi;
    cancel = c;
    disp_ready = d;
    tick();
  endtask

  task automatic expect_out(input string tag, input int ey, input int ev, input int eo, input int ec);
    chk({tag, "_y"}, int'(y), ey);
    chk({tag, "_coin_valid"}, int'(coin_valid), ev);
    chk({tag, "_coin_out"}, int'(coin_out), eo);
    chk({tag, "_credit"}, int'(credit), ec);
  endtask

  initial begin
    tick();
    chk_en = 1'b1;
    step(1, 2'b00, 0, 0);
    expect_out("reset", 0, 0, 0, 0);

    // Three 50-cent coins buy one drink exactly.
    step(0, 2'b01, 0, 0);
    expect_out("c1", 0, 0, 0, 1);
    step(0, 2'b01, 0, 0);
    expect_out("c2", 0, 0, 0, 2);
    step(0, 2'b01, 0, 0);
    expect_out("vend_exact", 1, 0, 0, 0);
    step(0, 2'b00, 0, 1);
    expect_out("after_exact", 0, 0, 0, 0);

    // Two Euros: vend then one 50-cent change coin; disp_ready during VEND is ignored.
    step(0, 2'b10, 0, 0);
    expect_out("e1", 0, 0, 0, 2);
    step(0, 2'b10, 0, 1);
    expect_out("vend_over", 1, 0, 0, 1);
    step(0, 2'b00, 0, 1);
    expect_out("change1", 0, 1, 1, 1);
    step(0, 2'b00, 0, 1);
    expect_out("change_done", 0, 0, 0, 0);

    // Cancel at credit 2 with a stalled dispenser.
    step(0, 2'b01, 0, 0);
    step(0, 2'b01, 0, 0);
    step(0, 2'b00, 1, 0);
    expect_out("cancel2", 0, 1, 2, 2);
    for (int i = 0; i < 3; i++) begin
      step(0, 2'b00, 0, 0);
      expect_out("stall", 0, 1, 2, 2);
    end
    step(0, 2'b00, 0, 1);
    expect_out("cancel2_done", 0, 0, 0, 0);

    // Cancel wins over a Euro in the same cycle; coins during RETURN are not credited.
    step(0, 2'b01, 0, 0);
    step(0, 2'b10, 1, 0);
    expect_out("cancel_prio", 0, 1, 1, 1);
    step(0, 2'b01, 0, 0);
    expect_out("ret_coin_ignored", 0, 1, 1, 1);
    step(0, 2'b00, 0, 1);
    expect_out("cancel1_done", 0, 0, 0, 0);

    // Cancel at zero credit still accepts the coin; invalid coins and disp_ready do nothing.
    step(0, 2'b01, 1, 1);
    expect_out("cancel_zero", 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 2'b11, 0, 1);
      expect_out("invalid_coin", 0, 0, 0, 1);
    end

    // Reset mid-RETURN discards pending change, even with a coin presented.
    step(0, 2'b00, 1, 0);
    expect_out("ret_before_rst", 0, 1, 1, 1);
    step(1, 2'b10, 1, 1);
    expect_out("rst_in_return", 0, 0, 0, 0);
    step(0, 2'b10, 0, 0);
    step(0, 2'b01, 0, 0);
    expect_out("post_rst_vend", 1, 0, 0, 0);
    step(0, 2'b00, 0, 0);
    expect_out("idle_end", 0, 0, 0, 0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
